// File: rtl/sync_ram_module.sv
// sync_ram_module
//   Single-port synchronous RAM with one shared address bus, a write enable
//   and registered read data. Depth is 2**ADDR_WIDTH words of DATA_WIDTH bits.
//   Every word and the output register are cleared by the asynchronous reset,
//   so no read can ever return uninitialised data.
//
// Ports
//   clk    in  1           clock; all state updates on the rising edge
//   rst_n  in  1           asynchronous active-low reset (clears mem and dout)
//   we     in  1           1 = write din to mem[addr], 0 = read mem[addr]
//   addr   in  ADDR_WIDTH  word address for the read or write
//   din    in  DATA_WIDTH  write data
//   dout   out DATA_WIDTH  registered read data (write-first on a write cycle)
module sync_ram_module #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // NOTE: the storage is cleared by an asynchronous reset, so it must be built
  // from resettable flip-flops; a vendor block RAM cannot clear every word at
  // once. That is intentional for this small scratch store.
  // NOTE: non-blocking assignments keep mem and dout updating from the same
  // pre-edge values, so a write and its write-first output agree cycle-exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      dout <= '0;
    end else if (we) begin
      mem[addr] <= din;
      // Write-first: the new data appears on dout at the same edge.
      dout      <= din;
    end else begin
      dout      <= mem[addr];
    end
  end

endmodule

// File: tb/tb_sync_ram_module.sv
// tb_sync_ram_module
//   Directed self-checking bench for sync_ram_module (8-bit data, 16 words).
//   Inputs are driven 1 time unit after a rising edge and dout is sampled at
//   the same point, well away from the next active edge.
module tb_sync_ram_module;

  logic       clk;
  logic       rst_n;
  logic       we;
  logic [3:0] addr;
  logic [7:0] din;
  logic [7:0] dout;

  int vectors;
  int miscompares;

  sync_ram_module #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (we),
    .addr (addr),
    .din  (din),
    .dout (dout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [7:0] observed,
                       input logic [7:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic do_write(input logic [3:0] a, input logic [7:0] d);
    we   = 1'b1;
    addr = a;
    din  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input logic [3:0] a);
    we   = 1'b0;
    addr = a;
    din  = 8'h00;
    @(posedge clk);
    #1;
  endtask

  task automatic read_all_zero(input string tag);
    for (int i = 0; i < 16; i++) begin
      do_read(4'(i));
      check($sformatf("%s_addr%0d", tag, i), dout, 8'h00);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n = 1'b0;
    we    = 1'b0;
    addr  = 4'h0;
    din   = 8'h00;

    // Power-on reset, released mid-cycle.
    #2;
    check("por_dout", dout, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Make dout nonzero, then assert reset between edges: dout clears at once.
    do_write(4'h2, 8'h5A);
    check("wr_first_addr2", dout, 8'h5A);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_dout", dout, 8'h00);
    #1;
    rst_n = 1'b1;
    read_all_zero("after_reset");

    // Write/read two addresses on back-to-back edges.
    do_write(4'h3, 8'hAA);
    check("wr_addr3_dout", dout, 8'hAA);
    do_write(4'h5, 8'h55);
    check("wr_addr5_dout", dout, 8'h55);
    do_read(4'h3);
    check("rd_addr3", dout, 8'hAA);
    do_read(4'h5);
    check("rd_addr5", dout, 8'h55);

    // dout is registered: changing addr without an edge must not move it.
    addr = 4'h3;
    #2;
    check("dout_holds_between_edges", dout, 8'h55);

    // Write-first then read back.
    do_write(4'h7, 8'h3C);
    check("write_first_addr7", dout, 8'h3C);
    do_read(4'h7);
    check("rd_addr7", dout, 8'h3C);

    // Boundary addresses and their neighbours.
    do_write(4'h0, 8'h01);
    do_write(4'hF, 8'hFF);
    do_read(4'h0);
    check("rd_addr0", dout, 8'h01);
    do_read(4'hF);
    check("rd_addr15", dout, 8'hFF);
    do_read(4'h1);
    check("rd_addr1_untouched", dout, 8'h00);
    do_read(4'hE);
    check("rd_addr14_untouched", dout, 8'h00);

    // Overwrite on consecutive edges.
    do_write(4'h9, 8'h11);
    do_write(4'h9, 8'h22);
    do_read(4'h9);
    check("rd_addr9_overwrite", dout, 8'h22);
    // Earlier data survives unrelated writes.
    do_read(4'h3);
    check("rd_addr3_retained", dout, 8'hAA);

    // Fill every word with {0xC, addr}, spot-check, then reset mid-stream.
    for (int i = 0; i < 16; i++) begin
      do_write(4'(i), {4'hC, 4'(i)});
    end
    check("fill_last_dout", dout, 8'hCF);
    do_read(4'h6);
    check("fill_rd_addr6", dout, 8'hC6);
    do_read(4'hA);
    check("fill_rd_addr10", dout, 8'hCA);
    // Start another write, then kill it with reset before its edge.
    we   = 1'b1;
    addr = 4'h4;
    din  = 8'h99;
    #2;
    rst_n = 1'b0;
    #1;
    check("midstream_reset_dout", dout, 8'h00);
    @(posedge clk);
    #1;
    check("reset_held_dout", dout, 8'h00);
    rst_n = 1'b1;
    read_all_zero("after_midstream_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
